// File: rtl/dmi_access_ctrl_if.sv
// DMI request/response channel between the DTM-side initiator (master) and
// the debug module (slave). The signal names map onto the block ports as follows:
//   req_valid  <-> dmi_req_valid_o     req_ready  <-> dmi_req_ready_i
//   req        <-> dmi_req_o           resp_valid <-> dmi_resp_valid_i
//   resp_ready <-> dmi_resp_ready_o    resp       <-> dmi_resp_i
interface dmi_access_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic [40:0] req;         // dmi_req_t  {addr[6:0], op[1:0], data[31:0]}
   logic        resp_valid;
   logic        resp_ready;
   logic [33:0] resp;        // dmi_resp_t {data[31:0], resp[1:0]}

   modport master (
      output req_valid, req, resp_ready,
      input  req_ready, resp_valid, resp
   );

   modport slave (
      input  req_valid, req, resp_ready,
      output req_ready, resp_valid, resp
   );
endinterface

// File: rtl/dmi_access_ctrl.sv
// DMI initiator: turns dmi DR updates from the JTAG TAP into DMI requests,
// collects the responses, keeps the sticky dmistat error and presents
// {addr, data, status} for DR capture.
// Optional feature: define DMI_TIMEOUT_EN to enable the response watchdog
// (TimeoutCycles cycles per state); without it the block waits indefinitely.
module dmi_access_ctrl #(
   parameter int unsigned TimeoutCycles = 32'd1024
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        capture_i,
   input  logic        update_i,
   input  logic [40:0] dr_i,
   output logic [40:0] dr_o,
   input  logic        dmireset_i,
   input  logic        dmihardreset_i,
   output logic [1:0]  dmistat_o,
   dmi_access_ctrl_if.master dmi
);

   localparam logic [1:0] OP_READ      = 2'h1;
   localparam logic [1:0] OP_WRITE     = 2'h2;
   localparam logic [1:0] STAT_NONE    = 2'h0;
   localparam logic [1:0] STAT_FAIL    = 2'h2;
   localparam logic [1:0] STAT_BUSY    = 2'h3;
   localparam logic [1:0] RESP_SUCCESS = 2'h0;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_READ       = 3'd1,
      ST_WAIT_READ  = 3'd2,
      ST_WRITE      = 3'd3,
      ST_WAIT_WRITE = 3'd4
   } state_e;

   // The watchdog limit must leave room for at least one cycle of progress.
   if (TimeoutCycles < 32'd2) begin : g_timeout_cfg_invalid
   end

   state_e      state_r;
   logic [6:0]  addr_r;
   logic [31:0] data_r;
   logic [1:0]  dmistat_r;
   logic        req_valid_r;
   logic [40:0] req_r;
   logic        resp_ready_r;

   logic [6:0]  dr_addr_s;
   logic [31:0] dr_data_s;
   logic [1:0]  dr_op_s;
   logic [1:0]  stat_eff_s;
   logic [1:0]  err_evt_s;
   logic [1:0]  stat_next_s;
   logic        in_flight_s;
   logic        req_phase_s;
   logic        wait_phase_s;
   logic        req_hs_s;
   logic        resp_hs_s;
   logic        progress_s;
   logic        busy_evt_s;
   logic        resp_err_s;
   logic        timeout_s;
   logic        start_ok_s;

   assign dr_addr_s    = dr_i[40:34];
   assign dr_data_s    = dr_i[33:2];
   assign dr_op_s      = dr_i[1:0];

   // A coincident dmireset is applied before the update/capture is judged.
   assign stat_eff_s   = dmireset_i ? STAT_NONE : dmistat_r;

   assign in_flight_s  = (state_r != ST_IDLE);
   assign req_phase_s  = (state_r == ST_READ) || (state_r == ST_WRITE);
   assign wait_phase_s = (state_r == ST_WAIT_READ) || (state_r == ST_WAIT_WRITE);
   assign req_hs_s     = req_valid_r & dmi.req_ready;
   assign resp_hs_s    = dmi.resp_valid & resp_ready_r;
   assign progress_s   = (req_phase_s & req_hs_s) | (wait_phase_s & resp_hs_s);
   assign busy_evt_s   = in_flight_s & (update_i | capture_i);
   assign resp_err_s   = wait_phase_s & resp_hs_s & (dmi.resp[1:0] != RESP_SUCCESS);
   assign start_ok_s   = (state_r == ST_IDLE) & update_i & (stat_eff_s == STAT_NONE);

`ifdef DMI_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TimeoutCycles);
   localparam logic [CntW-1:0] TmoLast = CntW'(TimeoutCycles - 32'd1);

   logic [CntW-1:0] tmo_cnt_r;

   assign timeout_s = in_flight_s & ~progress_s & (tmo_cnt_r == TmoLast);

   // Watchdog: counts cycles spent in the current busy state, restarts on every state change.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tmo_cnt_r <= {CntW{1'b0}};
      end else if (dmihardreset_i || !in_flight_s || progress_s || timeout_s) begin
         tmo_cnt_r <= {CntW{1'b0}};
      end else begin
         tmo_cnt_r <= tmo_cnt_r + {{(CntW-1){1'b0}}, 1'b1};
      end
   end
`else
   assign timeout_s = 1'b0;
`endif

   // Error event of this cycle: a busy collision outranks an operation failure.
   always_comb begin
      err_evt_s = STAT_NONE;
      if (busy_evt_s) begin
         err_evt_s = STAT_BUSY;
      end else if (resp_err_s || timeout_s) begin
         err_evt_s = STAT_FAIL;
      end else begin
         err_evt_s = STAT_NONE;
      end
   end

   // Sticky status: only a clear status can take a new error, so the first one wins.
   always_comb begin
      stat_next_s = stat_eff_s;
      if (stat_eff_s == STAT_NONE) begin
         stat_next_s = err_evt_s;
      end else begin
         stat_next_s = stat_eff_s;
      end
   end

   // Transaction FSM with registered request/response handshake outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r      <= ST_IDLE;
         addr_r       <= 7'h00;
         data_r       <= 32'h0000_0000;
         dmistat_r    <= STAT_NONE;
         req_valid_r  <= 1'b0;
         req_r        <= 41'h0;
         resp_ready_r <= 1'b1;
      end else if (dmihardreset_i) begin
         // Abandon the transaction; the captured addr/data stay visible.
         state_r      <= ST_IDLE;
         dmistat_r    <= STAT_NONE;
         req_valid_r  <= 1'b0;
         resp_ready_r <= 1'b1;
      end else begin
         dmistat_r <= stat_next_s;
         case (state_r)
            ST_IDLE: begin
               if (start_ok_s) begin
                  case (dr_op_s)
                     OP_READ: begin
                        addr_r       <= dr_addr_s;
                        req_r        <= {dr_addr_s, OP_READ, 32'h0000_0000};
                        req_valid_r  <= 1'b1;
                        resp_ready_r <= 1'b0;
                        state_r      <= ST_READ;
                     end
                     OP_WRITE: begin
                        addr_r       <= dr_addr_s;
                        data_r       <= dr_data_s;
                        req_r        <= {dr_addr_s, OP_WRITE, dr_data_s};
                        req_valid_r  <= 1'b1;
                        resp_ready_r <= 1'b0;
                        state_r      <= ST_WRITE;
                     end
                     default: begin
                        state_r <= ST_IDLE;
                     end
                  endcase
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_READ, ST_WRITE: begin
               if (req_hs_s) begin
                  req_valid_r  <= 1'b0;
                  resp_ready_r <= 1'b1;
                  state_r      <= (state_r == ST_READ) ? ST_WAIT_READ : ST_WAIT_WRITE;
               end else if (timeout_s) begin
                  req_valid_r  <= 1'b0;
                  resp_ready_r <= 1'b1;
                  state_r      <= ST_IDLE;
               end else begin
                  state_r <= state_r;
               end
            end
            ST_WAIT_READ, ST_WAIT_WRITE: begin
               if (resp_hs_s) begin
                  if (state_r == ST_WAIT_READ) begin
                     data_r <= dmi.resp[33:2];
                  end else begin
                     data_r <= data_r;
                  end
                  state_r <= ST_IDLE;
               end else if (timeout_s) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= state_r;
               end
            end
            default: begin
               state_r      <= ST_IDLE;
               req_valid_r  <= 1'b0;
               resp_ready_r <= 1'b1;
            end
         endcase
      end
   end

   assign dmi.req_valid  = req_valid_r;
   assign dmi.req        = req_r;
   assign dmi.resp_ready = resp_ready_r;
   assign dr_o           = {addr_r, data_r, dmistat_r};
   assign dmistat_o      = dmistat_r;

endmodule
